uart_baud_gen: RTL and testbench

//  Consumes the system clock and active-low reset, and is the first synthesizable stage of the UART.

---
 rtl/uart_baud_gen_pkg.sv | 10 +
 rtl/uart_baud_gen_if.sv | 45 ++++
 rtl/uart_rst_sync.sv | 20 ++
 rtl/uart_baud_gen.sv | 82 ++++++++
 tb/tb_uart_baud_gen.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_baud_gen_pkg.sv
// rtl/uart_baud_gen_pkg.sv - shared UART baud constants
package uart_baud_gen_pkg;

    localparam int UART_ACC_W          = 24;
    localparam int UART_OSR            = 16;
    // Increments are baud x OSR x 2^ACC_W / f_clk, rounded.
    localparam int UART_INC_115200_50M = 618475;
    localparam int UART_INC_9600_50M   = 51540;

endpackage

// File: rtl/uart_baud_gen_if.sv
// rtl/uart_baud_gen_if.sv - baud generator control/tick bundle (BAUD_RUNTIME_CFG_EN adds inc_i/inc_load)
interface uart_baud_gen_if #(
    parameter int OSR = 16
`ifdef BAUD_RUNTIME_CFG_EN
    ,
    parameter int ACC_W = 24
`endif
);
    localparam int OS_W = $clog2(OSR);

    logic            en;
    logic            phase_clr;
    logic            tick_os;
    logic            tick_bit;
    logic [OS_W-1:0] os_phase;
`ifdef BAUD_RUNTIME_CFG_EN
    logic [ACC_W-1:0] inc_i;
    logic             inc_load;
`endif

    modport master (
`ifdef BAUD_RUNTIME_CFG_EN
        output inc_i,
        output inc_load,
`endif
        output en,
        output phase_clr,
        input  tick_os,
        input  tick_bit,
        input  os_phase
    );

    modport slave (
`ifdef BAUD_RUNTIME_CFG_EN
        input  inc_i,
        input  inc_load,
`endif
        input  en,
        input  phase_clr,
        output tick_os,
        output tick_bit,
        output os_phase
    );

endinterface

// File: rtl/uart_rst_sync.sv
// rtl/uart_rst_sync.sv - 2-flop reset synchronizer, async assert / sync deassert
module uart_rst_sync (
    input  logic clk,
    input  logic async_rst_n,
    output logic rst_sync_n
);

    logic meta;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            meta       <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_sync_n <= meta;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional-NCO oversample/bit tick generator (macro BAUD_RUNTIME_CFG_EN)
module uart_baud_gen
    import uart_baud_gen_pkg::*;
#(
    parameter int ACC_W = UART_ACC_W,
    parameter int INC   = UART_INC_115200_50M,
    parameter int OSR   = UART_OSR
) (
    input  logic           clk_sys,
    input  logic           reset_l,
    output logic           rst_sync_n,
    uart_baud_gen_if.slave bus
);

    localparam int              OS_W    = $clog2(OSR);
    localparam logic [ACC_W-1:0] INC_V   = ACC_W'(INC);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             clr;
    logic [OS_W-1:0]  os_cnt;
    logic             tick_os_q;
    logic             tick_bit_q;

    uart_rst_sync u_rst_sync (
        .clk         (clk_sys),
        .async_rst_n (reset_l),
        .rst_sync_n  (rst_sync_n)
    );

`ifdef BAUD_RUNTIME_CFG_EN
    always_ff @(posedge clk_sys or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            inc <= INC_V;
        end else if (bus.inc_load) begin
            inc <= bus.inc_i;
        end
    end

    // A new rate restarts the phase so the first period is a full one.
    assign clr = bus.phase_clr | bus.inc_load;
`else
    assign inc = INC_V;
    assign clr = bus.phase_clr;
`endif

    assign sum   = {1'b0, acc} + {1'b0, inc};
    assign carry = sum[ACC_W];

    always_ff @(posedge clk_sys or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            acc        <= '0;
            os_cnt     <= '0;
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end else if (clr) begin
            // Clear wins over a coincident carry, dropping that tick.
            acc        <= '0;
            os_cnt     <= '0;
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end else if (bus.en) begin
            acc        <= sum[ACC_W-1:0];
            tick_os_q  <= carry;
            tick_bit_q <= carry && (os_cnt == OS_LAST);
            if (carry) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            end
        end else begin
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end
    end

    assign bus.tick_os  = tick_os_q;
    assign bus.tick_bit = tick_bit_q;
    assign bus.os_phase = os_cnt;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - directed self-checking bench for uart_baud_gen
module tb_uart_baud_gen;

    logic clk_sys;
    logic reset_l;
    logic rst_sync_n;

    int     total;
    int     bad;
    int     k;
    longint cur_inc;

    uart_baud_gen_if #(.OSR(16)) bus ();

    uart_baud_gen #(
        .ACC_W (24),
        .INC   (618475),
        .OSR   (16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_l    (reset_l),
        .rst_sync_n (rst_sync_n),
        .bus        (bus)
    );

    initial clk_sys = 1'b0;
    always #10 clk_sys = ~clk_sys;

    function automatic longint ticks_at(input longint n, input longint inc);
        return (n * inc) >> 24;
    endfunction

    // One enabled edge; expectations come from the closed form floor(k*inc/2^24).
    task automatic step_check();
        longint   e_prev;
        longint   e_now;
        logic     exp_tick;
        logic     exp_bit;
        logic [3:0] exp_ph;
        e_prev = ticks_at(longint'(k), cur_inc);
        k++;
        e_now  = ticks_at(longint'(k), cur_inc);
        exp_tick = (e_now != e_prev);
        exp_bit  = exp_tick && ((e_now % 16) == 0);
        exp_ph   = 4'(e_now % 16);
        @(posedge clk_sys); #1;
        total++;
        if (bus.tick_os !== exp_tick || bus.tick_bit !== exp_bit || bus.os_phase !== exp_ph) begin
            bad++;
            if (bad <= 20)
                $display("FAIL step k=%0d tick_os=%b want %b tick_bit=%b want %b os_phase=%0d want %0d",
                         k, bus.tick_os, exp_tick, bus.tick_bit, exp_bit, bus.os_phase, exp_ph);
        end
    endtask

    task automatic release_reset();
        @(negedge clk_sys);
        reset_l = 1'b1;
        @(posedge clk_sys); #1;
        total++;
        if (rst_sync_n !== 1'b0) begin
            bad++;
            $display("FAIL rst_edge1 rst_sync_n=%b want 0", rst_sync_n);
        end
        @(posedge clk_sys); #1;
        total++;
        if (rst_sync_n !== 1'b1 || bus.tick_os !== 1'b0 || bus.os_phase !== 4'd0) begin
            bad++;
            $display("FAIL rst_edge2 rst_sync_n=%b tick_os=%b os_phase=%0d want 1/0/0",
                     rst_sync_n, bus.tick_os, bus.os_phase);
        end
        k = 0;
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rst_sync_n !== 1'b0 || bus.tick_os !== 1'b0 || bus.tick_bit !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold rst_sync_n=%b tick_os=%b tick_bit=%b want 0/0/0",
                         rst_sync_n, bus.tick_os, bus.tick_bit);
            end
            @(posedge clk_sys); #1;
        end
        bus.en = 1'b1;
        release_reset();
    endtask

    task automatic test_first_ticks();
        for (int i = 0; i < 440; i++) begin
            step_check();
            if (k == 27 || k == 28) begin
                total++;
                if (bus.tick_os !== (k == 28)) begin
                    bad++;
                    $display("FAIL first_tick_os k=%0d tick_os=%b", k, bus.tick_os);
                end
            end
            if (k == 435) begin
                total++;
                if (bus.tick_bit !== 1'b1 || bus.os_phase !== 4'd0) begin
                    bad++;
                    $display("FAIL first_tick_bit tick_bit=%b os_phase=%0d want 1/0",
                             bus.tick_bit, bus.os_phase);
                end
            end
        end
    endtask

    task automatic test_accuracy();
        int cnt_os;
        int cnt_bit;
        int last;
        bus.phase_clr = 1'b1;
        @(posedge clk_sys); #1;
        bus.phase_clr = 1'b0;
        k = 0;
        cnt_os = 0;
        cnt_bit = 0;
        last = 0;
        for (int i = 0; i < 4000; i++) begin
            step_check();
            if (bus.tick_os === 1'b1) begin
                cnt_os++;
                if (last != 0) begin
                    total++;
                    if (k - last != 27 && k - last != 28) begin
                        bad++;
                        $display("FAIL os_gap gap=%0d want 27 or 28", k - last);
                    end
                end
                last = k;
            end
            if (bus.tick_bit === 1'b1) cnt_bit++;
        end
        total++;
        if (cnt_os != 147 || cnt_bit != 9) begin
            bad++;
            $display("FAIL accuracy_counts tick_os=%0d want 147 tick_bit=%0d want 9", cnt_os, cnt_bit);
        end
    endtask

    task automatic test_enable_hold();
        logic [3:0] held;
        for (int i = 0; i < 40 && bus.tick_os !== 1'b1; i++) step_check();
        held = bus.os_phase;
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_sys); #1;
            total++;
            if (bus.tick_os !== 1'b0 || bus.tick_bit !== 1'b0 || bus.os_phase !== held) begin
                bad++;
                $display("FAIL en_hold tick_os=%b tick_bit=%b os_phase=%0d want 0/0/%0d",
                         bus.tick_os, bus.tick_bit, bus.os_phase, held);
            end
        end
        bus.en = 1'b1;
        for (int i = 0; i < 80; i++) step_check();
    endtask

    task automatic test_phase_clr_priority();
        for (int i = 0; i < 40 && ticks_at(longint'(k + 1), cur_inc) == ticks_at(longint'(k), cur_inc); i++)
            step_check();
        bus.phase_clr = 1'b1;
        @(posedge clk_sys); #1;
        bus.phase_clr = 1'b0;
        total++;
        if (bus.tick_os !== 1'b0 || bus.tick_bit !== 1'b0 || bus.os_phase !== 4'd0) begin
            bad++;
            $display("FAIL clr_priority tick_os=%b tick_bit=%b os_phase=%0d want 0/0/0",
                     bus.tick_os, bus.tick_bit, bus.os_phase);
        end
        k = 0;
        for (int i = 0; i < 28; i++) begin
            step_check();
            if (k >= 27) begin
                total++;
                if (bus.tick_os !== (k == 28)) begin
                    bad++;
                    $display("FAIL clr_next_tick k=%0d tick_os=%b", k, bus.tick_os);
                end
            end
        end
        for (int i = 0; i < 40; i++) step_check();
        bus.en = 1'b0;
        bus.phase_clr = 1'b1;
        @(posedge clk_sys); #1;
        bus.phase_clr = 1'b0;
        bus.en = 1'b1;
        total++;
        if (bus.os_phase !== 4'd0) begin
            bad++;
            $display("FAIL clr_while_disabled os_phase=%0d want 0", bus.os_phase);
        end
        k = 0;
        for (int i = 0; i < 30; i++) step_check();
    endtask

    task automatic test_midop_reset();
        for (int i = 0; i < 100; i++) step_check();
        #4;
        reset_l = 1'b0;
        #1;
        total++;
        if (rst_sync_n !== 1'b0 || bus.os_phase !== 4'd0 || bus.tick_os !== 1'b0 || bus.tick_bit !== 1'b0) begin
            bad++;
            $display("FAIL midop_reset rst_sync_n=%b os_phase=%0d tick_os=%b tick_bit=%b want 0/0/0/0",
                     rst_sync_n, bus.os_phase, bus.tick_os, bus.tick_bit);
        end
        cur_inc = 618475;
        release_reset();
        for (int i = 0; i < 60; i++) step_check();
    endtask

`ifdef BAUD_RUNTIME_CFG_EN
    task automatic test_runtime_cfg();
        int last;
        bus.inc_i = 24'd51540;
        bus.inc_load = 1'b1;
        @(posedge clk_sys); #1;
        bus.inc_load = 1'b0;
        cur_inc = 51540;
        k = 0;
        last = 0;
        for (int i = 0; i < 16000; i++) begin
            step_check();
            if (bus.tick_bit === 1'b1) begin
                total++;
                if ((last == 0 && k != 5209) || (last != 0 && k - last != 5208 && k - last != 5209)) begin
                    bad++;
                    $display("FAIL bit_gap k=%0d last=%0d", k, last);
                end
                last = k;
            end
        end
        test_midop_reset();
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        k = 0;
        cur_inc = 618475;
        reset_l = 1'b0;
        bus.en = 1'b0;
        bus.phase_clr = 1'b0;
`ifdef BAUD_RUNTIME_CFG_EN
        bus.inc_i = '0;
        bus.inc_load = 1'b0;
`endif
        test_reset();
        test_first_ticks();
        test_accuracy();
        test_enable_hold();
        test_phase_clr_priority();
        test_midop_reset();
`ifdef BAUD_RUNTIME_CFG_EN
        test_runtime_cfg();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
